// File: rtl/mask_scanout_vga.sv
// Row consumer for the mask generator: ping-pong row buffering (pending + displayed)
// and 640x480@60 VGA serialisation with sync generation.
module mask_scanout_vga #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [0:H_VIS-1] mg_mask,
  input  logic             rp_valid,
  output logic             rp_ready,
  output logic             pixel,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             frame_start,
  output logic             underflow
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [0:H_VIS-1] line_buf;
  logic [0:H_VIS-1] pending;

  logic vis;
  logic last_h;
  logic last_v;
  logic next_vis;
  logic swap;
  logic accept;
  logic pix_next;

  // rp_ready is itself the "pending empty" flag, so acceptance never depends
  // combinationally on anything but rp_valid and a flop.
  assign accept   = rp_valid & rp_ready;
  assign vis      = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);
  assign last_h   = (h_cnt == H_LAST);
  assign last_v   = (v_cnt == V_LAST);
  assign next_vis = last_v || (v_cnt < (V_VIS_W - 10'd1));
  assign swap     = clk_en & last_h & next_vis;

  always_comb begin
    pix_next = 1'b0;
    if (vis) pix_next = line_buf[h_cnt];
  end

  // Timing chain: counters plus registered video outputs (one enabled cycle behind).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= V_VIS_W;
      pixel       <= 1'b0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= V_VIS_W;
      frame_start <= 1'b0;
    end else if (clk_en) begin
      h_cnt <= last_h ? '0 : h_cnt + 10'd1;
      if (last_h) v_cnt <= last_v ? '0 : v_cnt + 10'd1;
      video_on    <= vis;
      pixel       <= pix_next;
      hsync       <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vsync       <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

  // Row buffering. A swap on the last pixel of a line takes the pending row, or
  // bypasses an arriving row straight into the line buffer, or blanks the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_buf  <= '0;
      pending   <= '0;
      rp_ready  <= 1'b1;
      underflow <= 1'b0;
    end else if (swap) begin
      if (!rp_ready) begin
        line_buf <= pending;
        rp_ready <= 1'b1;
      end else if (rp_valid) begin
        line_buf <= mg_mask;
      end else begin
        line_buf  <= '0;
        underflow <= 1'b1;
      end
    end else if (accept) begin
      pending  <= mg_mask;
      rp_ready <= 1'b0;
    end
  end

endmodule

// File: doc/mask_scanout_vga.md
Name: mask_scanout_vga

Overview:
- Consumer end of the mask generator row interface.
- Accepts 640-bit mask rows via an mg_mask/rp_valid/rp_ready handshake and buffers them in a ping-pong pair: one pending row, one row being displayed.
- Serializes the displayed row onto a 640x480@60 VGA pixel stream with hsync/vsync.
- Sits between mask_generation_VGA and the display/DAC output stage.

Parameters:
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  pixel-clock enable; counters and video outputs advance only when high.
- mg_mask  in  [0:639]  mask row; bit 0 = leftmost pixel.
- rp_valid  in  1  mg_mask holds a valid row.
- rp_ready  out  1  pending buffer empty; row accepted when rp_valid && rp_ready.
- pixel  out  1  mask bit for the current pixel; 0 outside the visible area.
- video_on  out  1  current pixel is visible.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- pixel_x  out  10  horizontal counter value aligned with pixel.
- pixel_y  out  10  vertical counter value aligned with pixel.
- frame_start  out  1  one-enabled-cycle pulse aligned with pixel (0,0).
- underflow  out  1  sticky: a visible line started with no row available.

Behaviour:
- Clock and reset: single clk domain; rst_n is asynchronous and active-low.

Reset values:
- h_cnt=0, v_cnt=V_VIS (480, start of vertical blanking), giving the source 45 lines to supply row 0.
- pending buffer empty, line buffer all zero.
- Outputs: rp_ready=1, pixel=0, video_on=0, hsync=1, vsync=1, pixel_x=0, pixel_y=480, frame_start=0, underflow=0.
- Reset mid-frame discards both buffers; the next row accepted is treated as row 0 of the next frame.

Counters:
- Update only when clk_en=1.
- h_cnt counts 0..799 and wraps to 0.
- On wrap, v_cnt counts 0..524 and wraps to 0.

Video outputs:
- Registered; they reflect the counter state of the previous enabled cycle (1 enabled-cycle latency) and hold while clk_en=0.
- video_on = (h<640 && v<480).
- pixel = video_on ? line_buf[h] : 0.
- hsync low for 656<=h<=751; vsync low for 490<=v<=491.
- frame_start = (h==0 && v==0).

Handshake:
- Independent of clk_en; evaluated every clk.
- rp_ready = !pending_full, taken directly from a register with no combinational path from rp_valid.
- When rp_valid && rp_ready, mg_mask is captured into the pending buffer and pending_full is set.
- rp_valid held while rp_ready=0 is ignored; the producer must hold the row until acceptance.

Line swap:
- Occurs on the enabled cycle with h==799 where the next line is visible, i.e. v==524 or v<479.
- If pending_full: line_buf <= pending and pending_full is cleared, so rp_ready rises the next clk.
- Simultaneous swap and acceptance (pending empty, rp_valid=1): the incoming row is written directly into line_buf, pending stays empty, no underflow.
- Pending empty with no acceptance: line_buf is cleared to zero for that line and underflow is set.
- underflow stays set until reset.
- No swap during vertical blanking. A row accepted during blanking waits in pending for line 0.
- Per frame, exactly 480 rows are consumed, one per visible line, in order.

Width rules:
- pixel_x/pixel_y are unsigned 10-bit values equal to the counters, range 0..799 and 0..524.

Test Plan:
- Reset, then clk_en=1 for 800*525 cycles with rp_valid=0 -> hsync low for exactly 96 cycles per line, starting at registered h=656. vsync low for 2 lines (v=490..491). frame_start pulses once. underflow=1 after the first visible line.
- Supply row 0 = {32'h03D0A052, 608 zeros}, then rows 1..479 = all-zero during blanking -> line 0 pixels at x=0..31 match 0000_0011_1101_0000_1010_0000_0101_0010. All other pixels 0. underflow stays 0.
- Producer presents a new row every cycle -> rp_ready drops after the first acceptance and rises only on the clk after each line swap. Exactly 480 acceptances per frame, in order.
- Pending empty at h==799 of line 9 with rp_valid asserted that same cycle -> row appears on line 10 with no underflow.
- clk_en toggling 1/0 -> counters and outputs advance only on enabled cycles and the line period is 800 enabled cycles. Handshake acceptance still completes while clk_en=0.
- Assert rst_n=0 mid-line at v=100 -> outputs immediately return to reset values and rp_ready=1. After release, the first row accepted is displayed on v=0.
